// File: rtl/p405s_timereventgen.sv
// Timer event source: FIT/WD tap edge detection, PIT down-counter, watchdog
// reset-request sequencer and registered timer interrupt requests.
module p405s_timereventgen #(
  parameter int FIT_BASE = 9,
  parameter int WD_BASE  = 17,
  parameter int RST_HOLD = 8
) (
  input  logic        CB,
  input  logic        resetCore,
  input  logic        tbTick,
  input  logic [0:31] tbl,
  input  logic [0:1]  tcrWp,
  input  logic [0:1]  tcrFp,
  input  logic [0:1]  tcrWrc,
  input  logic        tcrWie,
  input  logic        tcrDie,
  input  logic        tcrFie,
  input  logic        tcrAre,
  input  logic        tsrEnw,
  input  logic        tsrWis,
  input  logic        tsrPis,
  input  logic        tsrFis,
  input  logic        pitWrEn,
  input  logic [0:31] pitWrData,
  output logic [0:31] pitValue,
  output logic        hwSetFitStatus,
  output logic        hwSetPitStatus,
  output logic        wdPulse,
  output logic        hwSetWdIntrp,
  output logic        hwSetWdRst,
  output logic [0:1]  wdRstType,
  output logic        wdRstReq,
  output logic        wdIntrpReq,
  output logic        pitIntrpReq,
  output logic        fitIntrpReq
);

  localparam int CW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(RST_HOLD - 1);

  // Big-endian bit numbering: weight 2^k lives at tbl[31-k].
  localparam int FIT_IDX0 = 31 - FIT_BASE;
  localparam int FIT_IDX1 = 31 - FIT_BASE - 4;
  localparam int FIT_IDX2 = 31 - FIT_BASE - 8;
  localparam int FIT_IDX3 = 31 - FIT_BASE - 12;
  localparam int WD_IDX0  = 31 - WD_BASE;
  localparam int WD_IDX1  = 31 - WD_BASE - 4;
  localparam int WD_IDX2  = 31 - WD_BASE - 8;
  localparam int WD_IDX3  = 31 - WD_BASE - 12;

  typedef enum logic {WD_IDLE, WD_RST} wd_state_e;

  wd_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [0:31]    pit_q, pit_d;
  logic [0:31]    reload_q, reload_d;
  logic           fit_hist_q, fit_hist_d;
  logic           wd_hist_q, wd_hist_d;
  logic           fit_set_q, fit_set_d;
  logic           pit_set_q, pit_set_d;
  logic           wd_pulse_q, wd_pulse_d;
  logic           wd_intrp_q, wd_intrp_d;
  logic           wd_rst_q, wd_rst_d;
  logic [0:1]     rst_type_q, rst_type_d;
  logic           wd_irq_q, wd_irq_d;
  logic           pit_irq_q, pit_irq_d;
  logic           fit_irq_q, fit_irq_d;
  logic           fit_tap, wd_tap, fit_evt, wd_evt;

  always_comb begin
    fit_tap = 1'b0;
    wd_tap  = 1'b0;
    case (tcrFp)
      2'd0:    fit_tap = tbl[FIT_IDX0];
      2'd1:    fit_tap = tbl[FIT_IDX1];
      2'd2:    fit_tap = tbl[FIT_IDX2];
      default: fit_tap = tbl[FIT_IDX3];
    endcase
    case (tcrWp)
      2'd0:    wd_tap = tbl[WD_IDX0];
      2'd1:    wd_tap = tbl[WD_IDX1];
      2'd2:    wd_tap = tbl[WD_IDX2];
      default: wd_tap = tbl[WD_IDX3];
    endcase
  end

  always_comb begin
    fit_evt    = fit_tap & ~fit_hist_q;
    wd_evt     = wd_tap & ~wd_hist_q;
    fit_hist_d = fit_tap;
    wd_hist_d  = wd_tap;
    fit_set_d  = fit_evt;

    pit_d     = pit_q;
    reload_d  = reload_q;
    pit_set_d = 1'b0;
    if (pitWrEn) begin
      pit_d    = pitWrData;
      reload_d = pitWrData;
    end else if (tbTick && (pit_q > 32'd1)) begin
      pit_d = pit_q - 32'd1;
    end else if (tbTick && (pit_q == 32'd1)) begin
      pit_set_d = 1'b1;
      pit_d     = tcrAre ? reload_q : '0;
    end

    state_d    = state_q;
    cnt_d      = cnt_q;
    wd_pulse_d = 1'b0;
    wd_intrp_d = 1'b0;
    wd_rst_d   = 1'b0;
    rst_type_d = rst_type_q;
    case (state_q)
      WD_IDLE: begin
        if (wd_evt) begin
          wd_pulse_d = 1'b1;
          if (tsrEnw && !tsrWis) begin
            wd_intrp_d = 1'b1;
          end else if (tsrEnw && tsrWis && (tcrWrc != 2'b00)) begin
            wd_rst_d   = 1'b1;
            rst_type_d = tcrWrc;
            state_d    = WD_RST;
            cnt_d      = HOLD_LOAD;
          end
        end
      end
      WD_RST: begin
        // Watchdog edges arriving while the request is held are dropped.
        if (cnt_q == '0) state_d = WD_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = WD_IDLE;
    endcase

    wd_irq_d  = tsrWis & tcrWie;
    pit_irq_d = tsrPis & tcrDie;
    fit_irq_d = tsrFis & tcrFie;
  end

  always_ff @(posedge CB or posedge resetCore) begin
    if (resetCore) begin
      state_q    <= WD_IDLE;
      cnt_q      <= '0;
      pit_q      <= '0;
      reload_q   <= '0;
      fit_hist_q <= 1'b1;
      wd_hist_q  <= 1'b1;
      fit_set_q  <= 1'b0;
      pit_set_q  <= 1'b0;
      wd_pulse_q <= 1'b0;
      wd_intrp_q <= 1'b0;
      wd_rst_q   <= 1'b0;
      rst_type_q <= '0;
      wd_irq_q   <= 1'b0;
      pit_irq_q  <= 1'b0;
      fit_irq_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pit_q      <= pit_d;
      reload_q   <= reload_d;
      fit_hist_q <= fit_hist_d;
      wd_hist_q  <= wd_hist_d;
      fit_set_q  <= fit_set_d;
      pit_set_q  <= pit_set_d;
      wd_pulse_q <= wd_pulse_d;
      wd_intrp_q <= wd_intrp_d;
      wd_rst_q   <= wd_rst_d;
      rst_type_q <= rst_type_d;
      wd_irq_q   <= wd_irq_d;
      pit_irq_q  <= pit_irq_d;
      fit_irq_q  <= fit_irq_d;
    end
  end

  assign pitValue       = pit_q;
  assign hwSetFitStatus = fit_set_q;
  assign hwSetPitStatus = pit_set_q;
  assign wdPulse        = wd_pulse_q;
  assign hwSetWdIntrp   = wd_intrp_q;
  assign hwSetWdRst     = wd_rst_q;
  assign wdRstType      = rst_type_q;
  assign wdRstReq       = (state_q == WD_RST);
  assign wdIntrpReq     = wd_irq_q;
  assign pitIntrpReq    = pit_irq_q;
  assign fitIntrpReq    = fit_irq_q;

endmodule

// File: tb/tb_p405s_timereventgen.sv
// Randomized and directed bench for p405s_timereventgen, compared every cycle
// against a behavioural model of the timer event rules.
module tb_p405s_timereventgen;

   localparam int FIT_BASE = 9;
   localparam int WD_BASE  = 17;
   localparam int RST_HOLD = 8;

   logic        CB = 1'b0;
   logic        resetCore = 1'b0;
   logic        tbTick = 1'b0;
   logic [31:0] tbl = '0;
   logic [1:0]  tcrWp = '0, tcrFp = '0, tcrWrc = '0;
   logic        tcrWie = 0, tcrDie = 0, tcrFie = 0, tcrAre = 0;
   logic        tsrEnw = 0, tsrWis = 0, tsrPis = 0, tsrFis = 0;
   logic        pitWrEn = 0;
   logic [31:0] pitWrData = '0;
   logic [31:0] pitValue;
   logic        hwSetFitStatus, hwSetPitStatus, wdPulse, hwSetWdIntrp, hwSetWdRst;
   logic [1:0]  wdRstType;
   logic        wdRstReq, wdIntrpReq, pitIntrpReq, fitIntrpReq;

   int nTests = 0;
   int nFail  = 0;

   p405s_timereventgen #(.FIT_BASE(FIT_BASE), .WD_BASE(WD_BASE), .RST_HOLD(RST_HOLD)) dut (
      .CB(CB), .resetCore(resetCore), .tbTick(tbTick), .tbl(tbl),
      .tcrWp(tcrWp), .tcrFp(tcrFp), .tcrWrc(tcrWrc),
      .tcrWie(tcrWie), .tcrDie(tcrDie), .tcrFie(tcrFie), .tcrAre(tcrAre),
      .tsrEnw(tsrEnw), .tsrWis(tsrWis), .tsrPis(tsrPis), .tsrFis(tsrFis),
      .pitWrEn(pitWrEn), .pitWrData(pitWrData), .pitValue(pitValue),
      .hwSetFitStatus(hwSetFitStatus), .hwSetPitStatus(hwSetPitStatus),
      .wdPulse(wdPulse), .hwSetWdIntrp(hwSetWdIntrp), .hwSetWdRst(hwSetWdRst),
      .wdRstType(wdRstType), .wdRstReq(wdRstReq), .wdIntrpReq(wdIntrpReq),
      .pitIntrpReq(pitIntrpReq), .fitIntrpReq(fitIntrpReq)
   );

   // Free-running clock, 10 time units per period.
   always #5 CB = ~CB;

   // Behavioural model state: expected output values after each rising edge.
   bit [31:0] mPit, mReload;
   bit        mFitPrev, mWdPrev;
   int        mHoldLeft;
   bit        mFit, mPitP, mWdP, mWdI, mWdR;
   bit [1:0]  mType;
   bit        mWdIrq, mPitIrq, mFitIrq;

   // Model update: taps taken arithmetically by weight, PIT as an integer,
   // the reset request as a remaining-cycle count.
   always @(posedge CB or posedge resetCore) begin : modelBlk
      int  fitExp, wdExp;
      bit  fitTap, wdTap, fitEdge, wdEdge;
      if (resetCore) begin
         mPit = 0; mReload = 0; mFitPrev = 1; mWdPrev = 1; mHoldLeft = 0;
         mFit = 0; mPitP = 0; mWdP = 0; mWdI = 0; mWdR = 0; mType = 0;
         mWdIrq = 0; mPitIrq = 0; mFitIrq = 0;
      end else begin
         fitExp  = FIT_BASE + 4 * int'(tcrFp);
         wdExp   = WD_BASE + 4 * int'(tcrWp);
         fitTap  = tbl[fitExp];
         wdTap   = tbl[wdExp];
         fitEdge = fitTap && !mFitPrev;
         wdEdge  = wdTap && !mWdPrev;
         mFitPrev = fitTap;
         mWdPrev  = wdTap;
         mFit     = fitEdge;

         mPitP = 0;
         if (pitWrEn) begin
            mPit = pitWrData; mReload = pitWrData;
         end else if (tbTick && mPit > 1) begin
            mPit = mPit - 1;
         end else if (tbTick && mPit == 1) begin
            mPitP = 1;
            mPit  = tcrAre ? mReload : 0;
         end

         mWdP = 0; mWdI = 0; mWdR = 0;
         if (mHoldLeft > 0) begin
            mHoldLeft = mHoldLeft - 1;
         end else if (wdEdge) begin
            mWdP = 1;
            if (tsrEnw && !tsrWis) mWdI = 1;
            else if (tsrEnw && tsrWis && tcrWrc != 0) begin
               mWdR = 1; mType = tcrWrc; mHoldLeft = RST_HOLD;
            end
         end

         mWdIrq  = tsrWis && tcrWie;
         mPitIrq = tsrPis && tcrDie;
         mFitIrq = tsrFis && tcrFie;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Per-cycle comparison of every output against the model, shortly after the edge.
   always begin
      @(posedge CB);
      #2;
      checkOutput("pitValue", pitValue, mPit);
      checkOutput("hwSetFitStatus", 32'(hwSetFitStatus), 32'(mFit));
      checkOutput("hwSetPitStatus", 32'(hwSetPitStatus), 32'(mPitP));
      checkOutput("wdPulse", 32'(wdPulse), 32'(mWdP));
      checkOutput("hwSetWdIntrp", 32'(hwSetWdIntrp), 32'(mWdI));
      checkOutput("hwSetWdRst", 32'(hwSetWdRst), 32'(mWdR));
      checkOutput("wdRstType", 32'(wdRstType), 32'(mType));
      checkOutput("wdRstReq", 32'(wdRstReq), 32'(mHoldLeft > 0));
      checkOutput("wdIntrpReq", 32'(wdIntrpReq), 32'(mWdIrq));
      checkOutput("pitIntrpReq", 32'(pitIntrpReq), 32'(mPitIrq));
      checkOutput("fitIntrpReq", 32'(fitIntrpReq), 32'(mFitIrq));
   end

   // Advance n clock cycles; inputs are always changed on the falling edge.
   task automatic applyStimulus(input int n);
      repeat (n) @(negedge CB);
   endtask

   task automatic wdEdge(input logic enw, input logic wis);
      tbl = 32'h0;
      applyStimulus(1);
      tbl = 32'h0002_0000;
      tsrEnw = enw; tsrWis = wis;
      applyStimulus(1);
   endtask

   // Directed sequences pin the model with literal values, then random traffic runs.
   initial begin : stimBlk
      int holdCnt;
      int k;
      #1 resetCore = 1'b1;
      applyStimulus(2);
      resetCore = 1'b0;
      applyStimulus(1);
      checkOutput("reset pitValue", pitValue, 32'd0);
      checkOutput("reset wdRstReq", 32'(wdRstReq), 32'd0);
      checkOutput("reset wdRstType", 32'(wdRstType), 32'd0);

      // FIT with FP=00: bit 9 rises at 0x200 and again at 0x600.
      tbl = 32'h1FF; applyStimulus(1);
      tbl = 32'h200; applyStimulus(1);
      checkOutput("fit at 0x200", 32'(hwSetFitStatus), 32'd1);
      tbl = 32'h201; applyStimulus(1);
      checkOutput("fit one cycle", 32'(hwSetFitStatus), 32'd0);
      tbl = 32'h5FF; applyStimulus(1);
      tbl = 32'h600; applyStimulus(1);
      checkOutput("fit at 0x600", 32'(hwSetFitStatus), 32'd1);

      // PIT one-shot from 3.
      tbTick = 1; pitWrEn = 1; pitWrData = 3; applyStimulus(1);
      checkOutput("pit write 3", pitValue, 32'd3);
      pitWrEn = 0; applyStimulus(1);
      checkOutput("pit 2", pitValue, 32'd2);
      applyStimulus(1);
      checkOutput("pit 1", pitValue, 32'd1);
      applyStimulus(1);
      checkOutput("pit 0", pitValue, 32'd0);
      checkOutput("pit pulse", 32'(hwSetPitStatus), 32'd1);
      applyStimulus(1);
      checkOutput("pit hold 0", pitValue, 32'd0);
      checkOutput("pit no repeat", 32'(hwSetPitStatus), 32'd0);

      // PIT auto-reload from 2, then write beats the expiring tick.
      tcrAre = 1; pitWrEn = 1; pitWrData = 2; applyStimulus(1);
      pitWrEn = 0; applyStimulus(1);
      checkOutput("are 1", pitValue, 32'd1);
      applyStimulus(1);
      checkOutput("are reload", pitValue, 32'd2);
      checkOutput("are pulse", 32'(hwSetPitStatus), 32'd1);
      applyStimulus(1);
      checkOutput("are 1 again", pitValue, 32'd1);
      pitWrEn = 1; pitWrData = 5; applyStimulus(1);
      checkOutput("write over expiry", pitValue, 32'd5);
      checkOutput("write no pulse", 32'(hwSetPitStatus), 32'd0);
      pitWrEn = 0; tbTick = 0; tcrAre = 0;

      // Watchdog escalation with WRC=10.
      tcrWp = 2'b00; tcrWrc = 2'b10;
      wdEdge(1'b0, 1'b0);
      checkOutput("wd first pulse", 32'(wdPulse), 32'd1);
      checkOutput("wd first no intr", 32'(hwSetWdIntrp), 32'd0);
      wdEdge(1'b1, 1'b0);
      checkOutput("wd second intr", 32'(hwSetWdIntrp), 32'd1);
      wdEdge(1'b1, 1'b1);
      checkOutput("wd third rst", 32'(hwSetWdRst), 32'd1);
      checkOutput("wd rst type", 32'(wdRstType), 32'd2);
      holdCnt = 1;
      for (int i = 0; i < 20; i++) begin
         if (i == 1) tbl = 32'h0;
         if (i == 3) tbl = 32'h0002_0000;
         applyStimulus(1);
         checkOutput("wd ignored in hold", 32'(wdPulse), 32'd0);
         if (!wdRstReq) break;
         holdCnt++;
      end
      checkOutput("wd hold length", 32'(holdCnt), 32'(RST_HOLD));

      // Reset in the middle of a hold drops everything at once.
      pitWrEn = 1; pitWrData = 100; applyStimulus(1);
      pitWrEn = 0;
      wdEdge(1'b1, 1'b1);
      applyStimulus(2);
      checkOutput("hold active", 32'(wdRstReq), 32'd1);
      resetCore = 1'b1;
      #1;
      checkOutput("async wdRstReq", 32'(wdRstReq), 32'd0);
      checkOutput("async pitValue", pitValue, 32'd0);
      applyStimulus(1);
      resetCore = 1'b0;
      tsrEnw = 0; tsrWis = 0; tcrWrc = 0;
      applyStimulus(1);

      // Interrupt request enables, one registered cycle behind.
      tsrWis = 1; tsrPis = 1; tsrFis = 1;
      applyStimulus(1);
      checkOutput("irq off", 32'({wdIntrpReq, pitIntrpReq, fitIntrpReq}), 32'd0);
      tcrWie = 1; tcrDie = 1; tcrFie = 1;
      #1;
      checkOutput("irq not yet", 32'({wdIntrpReq, pitIntrpReq, fitIntrpReq}), 32'd0);
      applyStimulus(1);
      checkOutput("irq on", 32'({wdIntrpReq, pitIntrpReq, fitIntrpReq}), 32'd7);

      // Random traffic, with jumps of tbl to just below tap boundaries.
      for (int c = 0; c < 4000; c++) begin
         tbTick = ($urandom_range(0, 3) != 0);
         if (tbTick) tbl = tbl + 1;
         if ($urandom_range(0, 15) == 0) begin
            k = (($urandom_range(0, 1) == 0) ? FIT_BASE : WD_BASE) + 4 * int'($urandom_range(0, 3));
            tbl = ($urandom & ~((32'h1 << (k + 1)) - 1)) | ((32'h1 << k) - 32'($urandom_range(1, 4)));
         end
         if ($urandom_range(0, 63) == 0) tcrFp = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 63) == 0) tcrWp = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 31) == 0) tcrWrc = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) {tcrWie, tcrDie, tcrFie, tcrAre} = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) {tsrEnw, tsrWis, tsrPis, tsrFis} = 4'($urandom_range(0, 15));
         pitWrEn = ($urandom_range(0, 15) == 0);
         pitWrData = 32'($urandom_range(0, 6));
         resetCore = ($urandom_range(0, 999) == 0);
         applyStimulus(1);
      end
      resetCore = 0; pitWrEn = 0;
      applyStimulus(2);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
